sync32_rx: RTL and testbench



---
 rtl/vlc_pkg.sv | 14 +
 rtl/vlc_sync_detect.sv | 44 ++++
 rtl/sync32_rx.sv | 90 +++++++++
 tb/tb_sync32_rx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlc_pkg.sv
// VLC link shared framing definitions.
// Holds the receiver state type and the default word/preamble constants.
package vlc_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam int         VLC_WORD_W   = 32;
  localparam int         VLC_SYNC_LEN = 8;
  localparam logic [7:0] VLC_SYNC_PAT = 8'hD5;

endpackage

// File: rtl/vlc_sync_detect.sv
// Preamble detector: LSB-first shift register, saturating fill counter
// and pattern compare. Ports: clk, reset, clear, shift, serial -> match.
module vlc_sync_detect
  import vlc_pkg::*;
#(
  parameter int                  SYNC_LEN     = VLC_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = SYNC_LEN'(VLC_SYNC_PAT)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic shift,
  input  logic serial,
  output logic match
);

  localparam int             FW   = $clog2(SYNC_LEN + 1);
  localparam logic [FW-1:0]  FULL = FW'(SYNC_LEN);

  logic [SYNC_LEN-1:0] sh;
  logic [SYNC_LEN-1:0] sh_nxt;
  logic [FW-1:0]       fill;
  logic [FW-1:0]       fill_nxt;

  always_comb begin
    sh_nxt   = {serial, sh[SYNC_LEN-1:1]};
    fill_nxt = (fill == FULL) ? fill : fill + 1'b1;
  end

  // Compare against the register contents as they will be after this bit,
  // so the lock decision includes the bit arriving now.
  assign match = shift && (fill_nxt == FULL) && (sh_nxt == SYNC_PATTERN);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sh   <= '0;
      fill <= '0;
    end else if (shift) begin
      sh   <= sh_nxt;
      fill <= fill_nxt;
    end
  end

endmodule

// File: rtl/sync32_rx.sv
// VLC serial receiver: hunts for the preamble, assembles WIDTH payload bits
// LSB first and strobes each word into the receive FIFO (overflow if full).
// Ports: iClk, iReset, iBit, iBitValid, iFull -> oData, oWrite, oOverflow,
// oLocked, oCount.
module sync32_rx
  import vlc_pkg::*;
#(
  parameter int                  WIDTH        = VLC_WORD_W,
  parameter int                  SYNC_LEN     = VLC_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = SYNC_LEN'(VLC_SYNC_PAT)
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iBit,
  input  logic             iBitValid,
  input  logic             iFull,
  output logic [WIDTH-1:0] oData,
  output logic             oWrite,
  output logic             oOverflow,
  output logic             oLocked,
  output logic [4:0]       oCount
);

  state_t           state;
  logic [WIDTH-2:0] word;
  logic             match;
  logic             last;

  assign last = (state == COLLECT) && iBitValid
             && (oCount == 5'(WIDTH - 1));

  vlc_sync_detect #(
    .SYNC_LEN     (SYNC_LEN),
    .SYNC_PATTERN (SYNC_PATTERN)
  ) u_sync (
    .clk    (iClk),
    .reset  (iReset),
    .clear  (last),
    .shift  (iBitValid && (state == HUNT)),
    .serial (iBit),
    .match  (match)
  );

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state     <= HUNT;
      word      <= '0;
      oData     <= '0;
      oWrite    <= 1'b0;
      oOverflow <= 1'b0;
      oLocked   <= 1'b0;
      oCount    <= '0;
    end else begin
      oWrite    <= 1'b0;
      oOverflow <= 1'b0;
      if (iBitValid) begin
        unique case (state)
          HUNT: begin
            if (match) begin
              state   <= COLLECT;
              oLocked <= 1'b1;
              oCount  <= '0;
            end
          end
          COLLECT: begin
            for (int i = 0; i < WIDTH - 1; i++) begin
              if (oCount == 5'(i)) word[i] <= iBit;
            end
            if (last) begin
              // The last bit goes straight into oData; the word is
              // dropped whole when the FIFO cannot take it.
              if (!iFull) begin
                oData  <= {iBit, word};
                oWrite <= 1'b1;
              end else begin
                oOverflow <= 1'b1;
              end
              state   <= HUNT;
              oLocked <= 1'b0;
              oCount  <= '0;
            end else begin
              oCount <= oCount + 5'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sync32_rx.sv
// Testbench for sync32_rx: frame table, directed corner sequences and
// random frames against a bit-list reference model.
module tb_sync32_rx;

  logic        iClk;
  logic        iReset;
  logic        iBit;
  logic        iBitValid;
  logic        iFull;
  logic [31:0] oData;
  logic        oWrite;
  logic        oOverflow;
  logic        oLocked;
  logic [4:0]  oCount;
  logic [31:0] d0_data;
  logic        d0_write;
  logic        d0_ovf;
  logic        d0_locked;
  logic [4:0]  d0_count;

  sync32_rx dut (
    .iClk      (iClk),
    .iReset    (iReset),
    .iBit      (iBit),
    .iBitValid (iBitValid),
    .iFull     (iFull),
    .oData     (oData),
    .oWrite    (oWrite),
    .oOverflow (oOverflow),
    .oLocked   (oLocked),
    .oCount    (oCount)
  );

  sync32_rx #(.SYNC_PATTERN(8'h00)) dut0 (
    .iClk      (iClk),
    .iReset    (iReset),
    .iBit      (iBit),
    .iBitValid (iBitValid),
    .iFull     (iFull),
    .oData     (d0_data),
    .oWrite    (d0_write),
    .oOverflow (d0_ovf),
    .oLocked   (d0_locked),
    .oCount    (d0_count)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int    nvec = 0;
  int    nmis = 0;
  int    cyc = 0;
  int    wr_cnt = 0;
  int    ovf_cnt = 0;
  int    last_wr_cyc = 0;
  int    prev_wr_cyc = 0;
  string phase = "init";

  // Reference model: recent bits as a list, payload as a bit array.
  logic [7:0]  pat = 8'hD5;
  bit          hist[$];
  bit          m_locked;
  int          m_cnt;
  logic [31:0] m_pay;
  logic [31:0] m_data;
  bit          m_wr;
  bit          m_ovf;

  task automatic model_edge(bit rst, bit v, bit b, bit f);
    bit ok;
    m_wr  = 0;
    m_ovf = 0;
    if (rst) begin
      hist.delete();
      m_locked = 0;
      m_cnt    = 0;
      m_data   = 0;
      return;
    end
    if (!v) return;
    if (!m_locked) begin
      hist.push_back(b);
      if (hist.size() > 8) void'(hist.pop_front());
      if (hist.size() == 8) begin
        ok = 1;
        for (int i = 0; i < 8; i++)
          if (hist[i] != pat[i]) ok = 0;
        if (ok) begin
          m_locked = 1;
          m_cnt    = 0;
        end
      end
    end else begin
      m_pay[m_cnt] = b;
      m_cnt++;
      if (m_cnt == 32) begin
        if (!f) begin
          m_data = m_pay;
          m_wr   = 1;
        end else begin
          m_ovf = 1;
        end
        m_locked = 0;
        m_cnt    = 0;
        hist.delete();
      end
    end
  endtask

  task automatic check_model();
    nvec++;
    if (oData !== m_data || oWrite !== m_wr || oOverflow !== m_ovf ||
        oLocked !== m_locked || oCount !== 5'(m_cnt)) begin
      nmis++;
      $display("FAIL %s cyc %0d: data %h/%h wr %b/%b ovf %b/%b lock %b/%b cnt %0d/%0d",
               phase, cyc, oData, m_data, oWrite, m_wr, oOverflow, m_ovf,
               oLocked, m_locked, oCount, m_cnt);
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s/%s: got %h, want %h", phase, nm, act, exp);
    end
  endtask

  task automatic step(bit rst, bit v, bit b, bit f);
    iReset    = rst;
    iBitValid = v;
    iBit      = b;
    iFull     = f;
    @(posedge iClk);
    model_edge(rst, v, b, f);
    #1;
    cyc++;
    check_model();
    if (oWrite) begin
      wr_cnt++;
      last_wr_cyc = cyc;
    end
    if (oOverflow) ovf_cnt++;
  endtask

  task automatic emit(bit b, bit f, bit gap);
    step(0, 1, b, f);
    if (gap) step(0, 0, 1'($urandom), 1'($urandom));
  endtask

  task automatic send_frame(logic [7:0] pre, logic [31:0] pay,
                            bit gap, bit full);
    for (int i = 0; i < 8; i++) emit(pre[i], 1'($urandom), gap);
    for (int i = 0; i < 32; i++)
      emit(pay[i], (i == 31) ? full : 1'($urandom), gap);
  endtask

  typedef struct {
    logic [31:0] pay;
    bit          gap;
    bit          full;
    int          exp_wr;
    int          exp_ovf;
    logic [31:0] exp_data;
    int          exp_dist;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bit seq[$];
    int last_i;

    tbl[0] = '{32'hA5C3_0F81, 0, 0, 1, 0, 32'hA5C3_0F81, 0};
    tbl[1] = '{32'hA5C3_0F81, 1, 0, 1, 0, 32'hA5C3_0F81, 0};
    tbl[2] = '{32'hDEAD_BEEF, 0, 1, 0, 1, 32'hA5C3_0F81, 0};
    tbl[3] = '{32'h0BAD_F00D, 0, 0, 1, 0, 32'h0BAD_F00D, 0};
    tbl[4] = '{32'hFFFF_FFFF, 0, 0, 1, 0, 32'hFFFF_FFFF, 0};
    tbl[5] = '{32'h1234_5678, 0, 0, 1, 0, 32'h1234_5678, 40};

    iReset = 1; iBit = 0; iBitValid = 0; iFull = 0;

    phase = "idle";
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1'($urandom), 1'($urandom));
      chk("data", oData, 0);
      chk("flags", {oWrite, oOverflow, oLocked}, 0);
      chk("count", 32'(oCount), 0);
    end

    phase = "table";
    for (int k = 0; k < 6; k++) begin
      wr_cnt  = 0;
      ovf_cnt = 0;
      send_frame(8'hD5, tbl[k].pay, tbl[k].gap, tbl[k].full);
      chk("writes", wr_cnt, tbl[k].exp_wr);
      chk("ovfs", ovf_cnt, tbl[k].exp_ovf);
      chk("data", oData, tbl[k].exp_data);
      if (tbl[k].exp_dist > 0)
        chk("dist", last_wr_cyc - prev_wr_cyc, tbl[k].exp_dist);
      prev_wr_cyc = last_wr_cyc;
    end

    phase = "hunt";
    step(1, 0, 0, 0);
    seq = '{1,1, 1,0,1,0,0,1,0,1,1, 1,0,1,0,1,0,1,1};
    last_i = seq.size() - 1;
    for (int i = 0; i < seq.size(); i++) begin
      step(0, 1, seq[i], 0);
      chk("lock", 32'(oLocked), 32'(i == last_i));
    end
    wr_cnt = 0;
    for (int i = 0; i < 32; i++) step(0, 1, (i == 0), 0);
    chk("writes", wr_cnt, 1);
    chk("data", oData, 32'h0000_0001);

    phase = "zero_pat";
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0);
      chk("d0_lock", 32'(d0_locked), 32'(i == 7));
    end
    step(1, 0, 0, 0);

    phase = "mid_reset";
    wr_cnt = 0;
    for (int i = 0; i < 8; i++) step(0, 1, pat[i], 0);
    for (int i = 0; i < 17; i++) step(0, 1, 1'($urandom), 0);
    chk("count17", 32'(oCount), 17);
    step(1, 1, 1, 0);
    chk("data", oData, 0);
    chk("flags", {oWrite, oOverflow, oLocked}, 0);
    chk("count", 32'(oCount), 0);
    for (int i = 0; i < 20; i++) step(0, 1, 1'($urandom), 0);
    chk("no_write", wr_cnt, 0);
    step(1, 0, 0, 0);
    send_frame(8'hD5, 32'hCAFE_0042, 0, 0);
    chk("writes", wr_cnt, 1);
    chk("data", oData, 32'hCAFE_0042);

    phase = "random";
    for (int f = 0; f < 30; f++) begin
      int n = $urandom_range(0, 5);
      logic [31:0] pay = $urandom;
      for (int i = 0; i < n; i++) step(0, 1, 1'($urandom), 0);
      for (int i = 0; i < 40; i++) begin
        bit b = (i < 8) ? pat[i] : pay[i-8];
        while ($urandom_range(0, 3) == 0)
          step(0, 0, 1'($urandom), 1'($urandom));
        if ($urandom_range(0, 99) == 0) step(1, 1, b, 0);
        else step(0, 1, b, ($urandom_range(0, 3) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
